// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N producers.
// Grants in bursts and tracks FIFO occupancy so the FIFO never overflows.
module fifo_wr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int BURST = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N-1:0]                 req,
    input  logic [N*WIDTH-1:0]           wdata,
    output logic [N-1:0]                 gnt,
    output logic [N-1:0]                 accept,
    output logic                         fifo_wr_ena,
    output logic [WIDTH-1:0]             fifo_data,
    input  logic                         fifo_rd_ena,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(BURST + 1);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] owner, owner_nx;
    logic [IW-1:0] rr, rr_nx;
    logic [IW-1:0] pick, idx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [N-1:0]  gnt_nx;
    logic          found;
    logic          space;
    logic          take;
    logic          rd_eff;

    assign space  = level < LW'(DEPTH);
    assign full   = level == LW'(DEPTH);
    assign rd_eff = fifo_rd_ena & (level != '0);
    assign take   = (state == BUSY) & req[owner] & space;

    // First requester at or above the round-robin pointer, with wrap.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(rr) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        accept = '0;
        if (take) accept[owner] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rr_nx    = rr;
        cnt_nx   = cnt;
        gnt_nx   = gnt;
        unique case (state)
            IDLE: begin
                if (found && space) begin
                    state_nx       = BUSY;
                    owner_nx       = pick;
                    cnt_nx         = '0;
                    gnt_nx         = '0;
                    gnt_nx[pick]   = 1'b1;
                end
            end
            BUSY: begin
                // A full FIFO only stalls; the grant is kept.
                if (!req[owner] || (take && cnt == CW'(BURST - 1))) begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    cnt_nx   = '0;
                    rr_nx    = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
                end else if (take) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            rr          <= '0;
            cnt         <= '0;
            gnt         <= '0;
            fifo_wr_ena <= 1'b0;
            fifo_data   <= '0;
            level       <= '0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            rr          <= rr_nx;
            cnt         <= cnt_nx;
            gnt         <= gnt_nx;
            fifo_wr_ena <= take;
            if (take) fifo_data <= wdata[int'(owner)*WIDTH +: WIDTH];
            level       <= level + LW'(take) - LW'(rd_eff);
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared against a cycle model of the arbitration and occupancy rules.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int BURST = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]  gnt;
    logic [N-1:0]  accept;
    logic          fifo_wr_ena;
    logic [W-1:0]  fifo_data;
    logic          fifo_rd_ena;
    logic [LW-1:0] level;
    logic          full;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.N(N), .WIDTH(W), .DEPTH(DEPTH), .BURST(BURST)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata),
        .gnt(gnt), .accept(accept), .fifo_wr_ena(fifo_wr_ena),
        .fifo_data(fifo_data), .fifo_rd_ena(fifo_rd_ena),
        .level(level), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int           m_owner = -1;
    int           m_cnt   = 0;
    int           m_rr    = 0;
    int           m_level = 0;
    logic         m_wr    = 1'b0;
    logic [W-1:0] m_data  = '0;
    logic         m_acc;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_acc;
    logic [W-1:0] sb[$];

    function automatic logic bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++)
            if (bit_of(r, (from + k) % N)) return (from + k) % N;
        return -1;
    endfunction

    always_comb begin
        m_acc = (m_owner >= 0) && (m_level < DEPTH) && bit_of(req, m_owner);
        exp_gnt = '0;
        if (m_owner >= 0) exp_gnt = {{(N-1){1'b0}}, 1'b1} << m_owner;
        exp_acc = m_acc ? exp_gnt : '0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_owner <= -1;
            m_cnt   <= 0;
            m_rr    <= 0;
            m_level <= 0;
            m_wr    <= 1'b0;
            m_data  <= '0;
            sb.delete();
        end else begin
            m_level <= m_level + (m_acc ? 1 : 0)
                     - ((fifo_rd_ena && m_level > 0) ? 1 : 0);
            m_wr <= m_acc;
            if (m_acc) begin
                m_data <= wdata[m_owner*W +: W];
                sb.push_back(wdata[m_owner*W +: W]);
            end
            if (m_owner < 0) begin
                if (req != '0 && m_level < DEPTH) begin
                    m_owner <= rr_pick(req, m_rr);
                    m_cnt   <= 0;
                end
            end else if (!bit_of(req, m_owner) || (m_acc && m_cnt + 1 == BURST)) begin
                m_owner <= -1;
                m_cnt   <= 0;
                m_rr    <= (m_owner + 1) % N;
            end else if (m_acc) begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic [N-1:0] r, input logic [N*W-1:0] d,
                        input logic rd);
        @(negedge clk);
        req         = r;
        wdata       = d;
        fifo_rd_ena = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        req         = '0;
        wdata       = '0;
        fifo_rd_ena = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        reset       = 1'b1;
        req         = 4'b1111;
        wdata       = 32'hDEADBEEF;
        fifo_rd_ena = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt got %b want 0000", gnt);
        end
        checks++;
        if (fifo_wr_ena !== 1'b0 || fifo_data !== 8'h00) begin
            errors++; $display("FAIL reset_wr got %b/%h want 0/00", fifo_wr_ena, fifo_data);
        end
        checks++;
        if (level !== 5'd0 || full !== 1'b0) begin
            errors++; $display("FAIL reset_level got %0d/%b want 0/0", level, full);
        end
        reset = 1'b0;
        req   = '0;
    endtask

    task automatic test_single();
        logic [7:0] w [3];
        int sent   = 0;
        int pulses = 0;
        int lim    = 0;
        logic prev = 1'b0;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
        do_reset();
        tick(4'b0001, {24'h0, w[0]}, 1'b0);
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL single_gnt_first got %b want 0000", gnt);
        end
        while (sent < 3 && lim < 20) begin
            tick(4'b0001, {24'h0, w[sent]}, 1'b0);
            lim++;
            if (lim == 1) begin
                checks++;
                if (gnt !== 4'b0001) begin
                    errors++; $display("FAIL single_gnt got %b want 0001", gnt);
                end
            end
            checks++;
            if (fifo_wr_ena !== prev) begin
                errors++; $display("FAIL single_wr_lat got %b want %b", fifo_wr_ena, prev);
            end
            if (fifo_wr_ena === 1'b1) begin
                checks++;
                if (fifo_data !== w[pulses]) begin
                    errors++; $display("FAIL single_data got %h want %h", fifo_data, w[pulses]);
                end
                pulses++;
            end
            prev = accept[0];
            if (accept[0]) sent++;
        end
        repeat (2) begin
            tick(4'b0000, 32'h0, 1'b0);
            if (fifo_wr_ena === 1'b1) begin
                checks++;
                if (fifo_data !== w[pulses]) begin
                    errors++; $display("FAIL single_data got %h want %h", fifo_data, w[pulses]);
                end
                pulses++;
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++; $display("FAIL single_pulses got %0d want 3", pulses);
        end
        checks++;
        if (level !== 5'd3 || gnt !== 4'b0000) begin
            errors++; $display("FAIL single_end got level %0d gnt %b want 3 0000", level, gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        int el;
        do_reset();
        for (int t = 0; t < 25; t++) begin
            tick(4'b1111, 32'hA3A2A1A0, 1'b1);
            eg = (t % 5 == 0) ? 4'b0000 : (4'b0001 << ((t / 5) % 4));
            el = (t == 0 || t % 5 == 1) ? 0 : 1;
            checks++;
            if (gnt !== eg || accept !== eg) begin
                errors++;
                $display("FAIL rr_gnt t=%0d got %b/%b want %b", t, gnt, accept, eg);
            end
            checks++;
            if (level !== LW'(el)) begin
                errors++; $display("FAIL rr_level t=%0d got %0d want %0d", t, level, el);
            end
        end
    endtask

    task automatic test_full();
        int sent = 0;
        int lim  = 0;
        bit dropped = 1'b0;
        do_reset();
        while (level !== 5'd16 && lim < 80) begin
            lim++;
            if (sent == 2 && !dropped) begin
                tick(4'b0000, 32'h0, 1'b0);
                dropped = 1'b1;
            end else begin
                tick(4'b0001, {24'h0, 8'(8'h40 + sent)}, 1'b0);
                if (accept[0]) sent++;
            end
        end
        checks++;
        if (level !== 5'd16 || sent != 16) begin
            errors++; $display("FAIL full_reach got level %0d sent %0d want 16 16", level, sent);
        end
        checks++;
        if (full !== 1'b1 || gnt !== 4'b0001 || accept !== 4'b0000) begin
            errors++;
            $display("FAIL full_stall got full %b gnt %b acc %b want 1 0001 0000", full, gnt, accept);
        end
        tick(4'b0001, {24'h0, 8'(8'h40 + sent)}, 1'b1);
        checks++;
        if (accept !== 4'b0000 || level !== 5'd16) begin
            errors++; $display("FAIL full_read_cycle got acc %b level %0d want 0000 16", accept, level);
        end
        tick(4'b0001, {24'h0, 8'(8'h40 + sent)}, 1'b0);
        checks++;
        if (level !== 5'd15 || accept !== 4'b0001 || full !== 1'b0) begin
            errors++; $display("FAIL full_after_read got level %0d acc %b want 15 0001", level, accept);
        end
        if (accept[0]) sent++;
        tick(4'b0001, {24'h0, 8'(8'h40 + sent)}, 1'b0);
        checks++;
        if (level !== 5'd16 || fifo_wr_ena !== 1'b1 || fifo_data !== 8'h50) begin
            errors++;
            $display("FAIL full_refill got level %0d wr %b data %h want 16 1 50", level, fifo_wr_ena, fifo_data);
        end
    endtask

    task automatic test_same_cycle();
        int sent = 0;
        bit hit  = 1'b0;
        do_reset();
        for (int lim = 0; lim < 60 && !hit; lim++) begin
            tick(4'b0001, {24'h0, 8'(sent)}, 1'b0);
            if (level === 5'd5 && accept === 4'b0001) begin
                fifo_rd_ena = 1'b1;
                hit = 1'b1;
            end else if (accept[0]) begin
                sent++;
            end
        end
        tick(4'b0000, 32'h0, 1'b0);
        checks++;
        if (!hit || level !== 5'd5) begin
            errors++; $display("FAIL same_cycle got hit %0d level %0d want 1 5", hit, level);
        end
        do_reset();
        tick(4'b0000, 32'h0, 1'b1);
        tick(4'b0000, 32'h0, 1'b0);
        checks++;
        if (level !== 5'd0) begin
            errors++; $display("FAIL read_empty got level %0d want 0", level);
        end
    endtask

    task automatic test_reset_mid();
        int  sent = 0;
        bit  hit  = 1'b0;
        do_reset();
        for (int lim = 0; lim < 60 && !hit; lim++) begin
            tick(4'b0100, {8'h00, 8'(sent), 16'h0}, 1'b0);
            if (level === 5'd7 && gnt === 4'b0100) hit = 1'b1;
            else if (accept[2]) sent++;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL mid_setup got level %0d gnt %b want 7 0100", level, gnt);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b1100;
        wdata = 32'hB3B20000;
        #1;
        checks++;
        if (gnt !== 4'b0000 || level !== 5'd0 || fifo_wr_ena !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got gnt %b level %0d wr %b want 0000 0 0", gnt, level, fifo_wr_ena);
        end
        tick(4'b1100, 32'hB3B20000, 1'b0);
        checks++;
        if (gnt !== 4'b0100) begin
            errors++; $display("FAIL mid_regrant got %b want 0100", gnt);
        end
    endtask

    task automatic test_release();
        int sent = 0;
        for (int lim = 0; lim < 20 && sent < 2; lim++) begin
            tick(4'b0100, {8'h00, 8'(8'hC0 + sent), 16'h0}, 1'b0);
            if (accept[2]) sent++;
        end
        tick(4'b1011, 32'hD300D1D0, 1'b0);
        checks++;
        if (gnt !== 4'b0100 || accept !== 4'b0000) begin
            errors++; $display("FAIL rel_drop got gnt %b acc %b want 0100 0000", gnt, accept);
        end
        tick(4'b1011, 32'hD300D1D0, 1'b0);
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL rel_idle got %b want 0000", gnt);
        end
        tick(4'b1011, 32'hD300D1D0, 1'b0);
        checks++;
        if (gnt !== 4'b1000 || accept !== 4'b1000) begin
            errors++; $display("FAIL rel_next got gnt %b acc %b want 1000 1000", gnt, accept);
        end
    endtask

    task automatic test_random();
        logic [N-1:0]   pend;
        logic [W-1:0]   pdata [N];
        logic [N-1:0]   r;
        logic [N*W-1:0] d;
        logic [W-1:0]   want;
        int             pct;
        do_reset();
        pend = '0;
        for (int i = 0; i < N; i++) pdata[i] = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            pct = ((cyc / 500) % 2 == 1) ? 70 : 20;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = 8'($urandom);
                end
            end
            r = pend;
            for (int i = 0; i < N; i++)
                d[i*W +: W] = pend[i] ? pdata[i] : 8'($urandom);
            tick(r, d, $urandom_range(0, 99) < pct);
            checks++;
            if (gnt !== exp_gnt || accept !== exp_acc) begin
                errors++;
                $display("FAIL rnd_gnt c=%0d got %b/%b want %b/%b", cyc, gnt, accept, exp_gnt, exp_acc);
            end
            checks++;
            if (level !== LW'(m_level) || full !== (m_level == DEPTH)) begin
                errors++; $display("FAIL rnd_level c=%0d got %0d want %0d", cyc, level, m_level);
            end
            checks++;
            if (fifo_wr_ena !== m_wr || fifo_data !== m_data) begin
                errors++;
                $display("FAIL rnd_wr c=%0d got %b/%h want %b/%h", cyc, fifo_wr_ena, fifo_data, m_wr, m_data);
            end
            if (fifo_wr_ena === 1'b1) begin
                want = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                checks++;
                if (fifo_data !== want) begin
                    errors++; $display("FAIL rnd_order c=%0d got %h want %h", cyc, fifo_data, want);
                end
            end
            for (int i = 0; i < N; i++)
                if (exp_acc[i]) pend[i] = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        req         = '0;
        wdata       = '0;
        fifo_rd_ena = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_same_cycle();
        test_reset_mid();
        do_reset();
        test_release();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
